// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: single-cycle mult/multu, 32-step restoring div/divu.
// Optional macro DIV_ZERO_EARLY_EN short-circuits divide-by-zero to finish in cycle 2.
module muldiv_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, DIV_ON, DIV_ZERO, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] rem_q, quot_q, divisor_q;
  logic        neg_quot, neg_rem, done_q;

  logic [63:0] mul_a, mul_b, product;
  logic [31:0] abs1, abs2;
  logic [32:0] trial, diff;
  logic [31:0] rem_next, quot_next, rem_final, quot_final;

  // op[0] selects signed handling; sign-extending to 64 bits keeps the low 64 product bits exact
  always_comb begin
    mul_a   = op[0] ? {{32{src1[31]}}, src1} : {32'b0, src1};
    mul_b   = op[0] ? {{32{src2[31]}}, src2} : {32'b0, src2};
    product = mul_a * mul_b;
    abs1    = (op[0] && src1[31]) ? (~src1 + 32'd1) : src1;
    abs2    = (op[0] && src2[31]) ? (~src2 + 32'd1) : src2;

    trial = {rem_q, quot_q[31]};
    diff  = trial - {1'b0, divisor_q};
    if (!diff[32]) begin
      rem_next  = diff[31:0];
      quot_next = {quot_q[30:0], 1'b1};
    end else begin
      rem_next  = trial[31:0];
      quot_next = {quot_q[30:0], 1'b0};
    end
    quot_final = neg_quot ? (~quot_next + 32'd1) : quot_next;
    rem_final  = neg_rem  ? (~rem_next  + 32'd1) : rem_next;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state     <= IDLE;
      count     <= 6'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      done_q    <= 1'b0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      divisor_q <= 32'd0;
      neg_quot  <= 1'b0;
      neg_rem   <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (!op[1]) begin
              {hi, lo} <= product;
              state    <= DONE;
              done_q   <= 1'b1;
            end
`ifdef DIV_ZERO_EARLY_EN
            else if (src2 == 32'd0) begin
              quot_q <= src1;
              state  <= DIV_ZERO;
            end
`endif
            else begin
              rem_q     <= 32'd0;
              quot_q    <= abs1;
              divisor_q <= abs2;
              neg_quot  <= op[0] & (src1[31] ^ src2[31]);
              neg_rem   <= op[0] & src1[31];
              count     <= 6'd0;
              state     <= DIV_ON;
            end
          end
        end
        // quot_q starts as the dividend and shifts out one bit as each quotient bit enters
        DIV_ON: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          count  <= count + 6'd1;
          if (count == 6'd31) begin
            hi     <= rem_final;
            lo     <= quot_final;
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DIV_ZERO: begin
          hi     <= quot_q;
          lo     <= 32'hFFFF_FFFF;
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done      = done_q && !cpu_rst;
  assign busy      = (state != IDLE) && !cpu_rst;
  assign stall_req = !cpu_rst && (((state == IDLE) && start && !flush) ||
                                  (state == DIV_ON) || (state == DIV_ZERO));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver pushes model results, a monitor pops on done.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        stall_req, done, busy;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cycle_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (rst),
    .start      (start),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .stall_req  (stall_req),
    .done       (done),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle_cnt, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic, SV division truncates toward zero
  task automatic refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint          sa, sb_v, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    lat = 1;
    eh = 32'd0;
    el = 32'd0;
    if (!o[1]) begin
      if (o[0]) begin
        p = sa * sb_v;
        eh = p[63:32]; el = p[31:0];
      end else begin
        up = ua * ub;
        eh = up[63:32]; el = up[31:0];
      end
    end else if (b == 32'd0) begin
`ifdef DIV_ZERO_EARLY_EN
      lat = 2;
`else
      lat = 33;
`endif
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      lat = 33;
      if (o[0]) begin
        q = sa / sb_v; r = sa % sb_v;
        eh = r[31:0]; el = q[31:0];
      end else begin
        uq = ua / ub; ur = ua % ub;
        eh = ur[31:0]; el = uq[31:0];
      end
    end
  endtask

  // Called at posedge+1; issues one op and checks stall/busy through to the cycle after done
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit noise);
    logic [31:0] eh, el;
    int lat;
    refModel(o, a, b, eh, el, lat);
    sb.push_back('{hi: eh, lo: el, done_cyc: cycle_cnt + lat});
    last_hi = eh;
    last_lo = el;
    op = o; src1 = a; src2 = b; start = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      checkOutput("stall_req", {63'd0, stall_req}, {63'd0, k < lat});
      checkOutput("busy", {63'd0, busy}, {63'd0, k > 0});
      @(posedge clk); #1;
      if (noise && (k + 1 <= lat)) begin
        start = 1'b1; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic flushScenario(input bit new_start);
    op = 2'b11; src1 = 32'd1000; src2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("busy_before_flush", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("hi_after_flush", {32'd0, hi}, {32'd0, last_hi});
    checkOutput("lo_after_flush", {32'd0, lo}, {32'd0, last_lo});
    if (new_start) begin
      applyStimulus(2'b00, 32'd12345, 32'd678, 1'b0);
    end else begin
      @(negedge clk);
      checkOutput("stall_after_flush", {63'd0, stall_req}, 64'd0);
      checkOutput("busy_after_flush", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done cycle=%0d got hi=%h lo=%h expected no done",
                   cycle_cnt, hi, lo);
        end else begin
          e = sb.pop_front();
          checkOutput("hi", {32'd0, hi}, {32'd0, e.hi});
          checkOutput("lo", {32'd0, lo}, {32'd0, e.lo});
          checkOutput("done_cycle", 64'(cycle_cnt), 64'(e.done_cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d got no finish expected finish", cycle_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b01;
    src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {63'd0, stall_req}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    applyStimulus(2'b10, 32'h0000_0007, 32'h0000_0000, 1'b0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

    $display("[TB] flush cases");
    flushScenario(1'b0);
    flushScenario(1'b1);

    // start and flush together in IDLE: flush wins
    op = 2'b01; src1 = 32'd3; src2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkOutput("stall_start_flush", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("busy_start_flush", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    $display("[TB] reset during divide");
    op = 2'b11; src1 = 32'd5000; src2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_stall", {63'd0, stall_req}, 64'd0);
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_hi", {32'd0, hi}, 64'd0);
    checkOutput("midrst_lo", {32'd0, lo}, 64'd0);
    last_hi = 32'd0;
    last_lo = 32'd0;
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] random cases");
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      if (o == 2'b11 && b == 32'd0) b = 32'd1;
      if (o == 2'b10 && $urandom_range(0, 5) == 0) b = 32'd0;
      applyStimulus(o, a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
